// File: rtl/creg_bus_arbiter_if.sv
// Bundle between NUM_REQ requesters, the arbiter, and the control-register port.
// Handshake: a requester holds IN_req[i] (and its fields) stable until it sees OUT_grant[i];
// the access transfers on the rising edge where IN_req[i] & OUT_grant[i].
interface creg_bus_arbiter_if #(
    parameter int NUM_REQ = 3
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    IN_req;
    logic [NUM_REQ-1:0]    IN_write;
    logic [4*NUM_REQ-1:0]  IN_wm;
    logic [7*NUM_REQ-1:0]  IN_addr;
    logic [32*NUM_REQ-1:0] IN_wdata;
    logic [NUM_REQ-1:0]    OUT_grant;
    logic [NUM_REQ-1:0]    OUT_rdValid;
    logic [31:0]           OUT_rdData;

    logic                  OUT_ce;
    logic                  OUT_we;
    logic [3:0]            OUT_wm;
    logic [6:0]            OUT_addr;
    logic [31:0]           OUT_data;
    logic [31:0]           IN_data;
    logic                  IN_IO_busy;

    logic [IW-1:0]         dbg_rr;
    logic [1:0]            dbg_io_hold;

    modport slave (
        input  IN_req, IN_write, IN_wm, IN_addr, IN_wdata, IN_data, IN_IO_busy,
        output OUT_grant, OUT_rdValid, OUT_rdData,
        output OUT_ce, OUT_we, OUT_wm, OUT_addr, OUT_data,
        output dbg_rr, dbg_io_hold
    );

    modport master (
        output IN_req, IN_write, IN_wm, IN_addr, IN_wdata, IN_data, IN_IO_busy,
        input  OUT_grant, OUT_rdValid, OUT_rdData,
        input  OUT_ce, OUT_we, OUT_wm, OUT_addr, OUT_data,
        input  dbg_rr, dbg_io_hold
    );
endinterface

// File: rtl/creg_bus_arbiter.sv
// Round-robin arbiter sharing the control-register port between NUM_REQ requesters,
// with read-response routing and SPI/GPIO (regs 4/5) busy sequencing.
module creg_bus_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int RD_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    creg_bus_arbiter_if.slave     bus
);
    localparam int IW   = $clog2(NUM_REQ);
    localparam int PIPE = RD_LAT + 1;

    logic [IW-1:0]      rr;
    logic [1:0]         io_hold;

    logic [NUM_REQ-1:0] is_io;
    logic [NUM_REQ-1:0] eligible;
    logic               grant_any;
    logic [IW-1:0]      grant_idx;
    logic               accept;

    logic               sel_write;
    logic               sel_io;
    logic [3:0]         sel_wm;
    logic [6:0]         sel_addr;
    logic [31:0]        sel_wdata;

    logic               ce_q;
    logic               we_q;
    logic [3:0]         wm_q;
    logic [6:0]         addr_q;
    logic [31:0]        data_q;
    logic [NUM_REQ-1:0] rd_valid_q;
    logic [31:0]        rd_data_q;

    logic               pipe_vld [PIPE];
    logic [IW-1:0]      pipe_idx [PIPE];

    always_comb begin
        logic [6:0] a;
        a = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a           = bus.IN_addr[7*i +: 7];
            is_io[i]    = (a[5] == 1'b0) && ((a[3:0] == 4'd4) || (a[3:0] == 4'd5));
            eligible[i] = bus.IN_req[i] &&
                          (!is_io[i] || (!bus.IN_IO_busy && (io_hold == 2'd0)));
        end
    end

    // First eligible requester at or after rr, wrapping; ineligible ones are skipped.
    always_comb begin
        int j;
        j         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!grant_any && eligible[j]) begin
                grant_any = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    assign accept = grant_any && rst;

    always_comb begin
        sel_write = 1'b0;
        sel_io    = 1'b0;
        sel_wm    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == grant_idx) begin
                sel_write = bus.IN_write[i];
                sel_io    = is_io[i];
                sel_wm    = bus.IN_wm[4*i +: 4];
                sel_addr  = bus.IN_addr[7*i +: 7];
                sel_wdata = bus.IN_wdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr         <= '0;
            io_hold    <= 2'd0;
            ce_q       <= 1'b1;
            we_q       <= 1'b1;
            wm_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            for (int s = 0; s < PIPE; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_idx[s] <= '0;
            end
        end else begin
            if (accept) begin
                ce_q   <= 1'b0;
                we_q   <= ~sel_write;
                wm_q   <= sel_wm;
                addr_q <= sel_addr;
                data_q <= sel_wdata;
                rr     <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                ce_q <= 1'b1;
                we_q <= 1'b1;
            end

            // Covers the edges before the downstream busy flag reflects a new IO access.
            if (accept && sel_io) begin
                io_hold <= 2'd3;
            end else if (io_hold != 2'd0) begin
                io_hold <= io_hold - 2'd1;
            end

            pipe_vld[0] <= accept && !sel_write;
            pipe_idx[0] <= grant_idx;
            for (int s = 1; s < PIPE; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_idx[s] <= pipe_idx[s-1];
            end

            if (pipe_vld[PIPE-1]) begin
                rd_valid_q <= NUM_REQ'(1) << pipe_idx[PIPE-1];
                rd_data_q  <= bus.IN_data;
            end else begin
                rd_valid_q <= '0;
            end
        end
    end

    assign bus.OUT_grant   = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign bus.OUT_rdValid = rd_valid_q;
    assign bus.OUT_rdData  = rd_data_q;
    assign bus.OUT_ce      = ce_q;
    assign bus.OUT_we      = we_q;
    assign bus.OUT_wm      = wm_q;
    assign bus.OUT_addr    = addr_q;
    assign bus.OUT_data    = data_q;
    assign bus.dbg_rr      = rr;
    assign bus.dbg_io_hold = io_hold;
endmodule
